// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and default width for the bit-serial ALU.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_SUMA  = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_RESTA = 3'd4;
  localparam logic [2:0] OP_SLT   = 3'd5;
  localparam logic [2:0] OP_SLTU  = 3'd6;
  localparam logic [2:0] OP_NULA  = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/ALU.sv
// 1-bit ALU slice: full adder with optional B inversion plus bitwise ops.
module ALU
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic       invert_i,
  input  logic       less_i,
  input  logic       lessunsigned_i,
  input  logic [2:0] op_i,
  output logic       r_o,
  output logic       c_o
);

  logic w_b;
  logic w_sum;

  assign w_b   = b_i ^ invert_i;
  assign w_sum = a_i ^ w_b ^ c_i;
  assign c_o   = (a_i & w_b) | (a_i & c_i) | (w_b & c_i);

  always_comb begin
    r_o = 1'b0;
    case (op_i)
      OP_SUMA:  r_o = w_sum;
      OP_AND:   r_o = a_i & w_b;
      OP_OR:    r_o = a_i | w_b;
      OP_XOR:   r_o = a_i ^ w_b;
      OP_RESTA: r_o = w_sum;
      OP_SLT:   r_o = less_i;
      OP_SLTU:  r_o = lessunsigned_i;
      OP_NULA:  r_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU: one slice evaluation per clock, LSB first, with
// SLT/SLTU fix-up and registered flags on the final bit.
module alu_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       operacion_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] resultado_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_a, w_a_next;
  logic [WIDTH-1:0]   r_b, w_b_next;
  logic [WIDTH-2:0]   r_sh, w_sh_next;
  logic [2:0]         r_op, w_op_next;
  logic [CntW-1:0]    r_cnt, w_cnt_next;
  logic               r_carry, w_carry_next;
  logic [WIDTH-1:0]   r_res, w_res_next;
  logic               r_zero, w_zero_next;
  logic               r_cout, w_cout_next;
  logic               r_ovf, w_ovf_next;

  logic               w_slice_r, w_slice_c, w_invert;
  logic [2:0]         w_slice_op;
  logic [WIDTH-1:0]   w_sh_full;
  logic               w_last, w_is_sub;
  logic               w_ovf_add, w_ovf_sub;
  logic [WIDTH-1:0]   w_fin_res;
  logic               w_fin_cout, w_fin_ovf;

  assign w_is_sub = (r_op == OP_RESTA) || (r_op == OP_SLT) || (r_op == OP_SLTU);

  always_comb begin
    w_slice_op = r_op;
    w_invert   = 1'b0;
    if (w_is_sub) begin
      w_slice_op = OP_RESTA;
      w_invert   = 1'b1;
    end
  end

  ALU u_alu (
    .a_i            (r_a[0]),
    .b_i            (r_b[0]),
    .c_i            (r_carry),
    .invert_i       (w_invert),
    .less_i         (1'b0),
    .lessunsigned_i (1'b0),
    .op_i           (w_slice_op),
    .r_o            (w_slice_r),
    .c_o            (w_slice_c)
  );

  // r_sh holds bits 0..WIDTH-2; the slice output completes the word on the last bit.
  assign w_sh_full = {w_slice_r, r_sh};
  assign w_last    = (r_cnt == CntW'(WIDTH - 1));

  assign w_ovf_sub = (r_a[0] != r_b[0]) & (w_slice_r != r_a[0]);
  assign w_ovf_add = (r_a[0] == r_b[0]) & (w_slice_r != r_a[0]);

  always_comb begin
    w_fin_res  = w_sh_full;
    w_fin_cout = 1'b0;
    w_fin_ovf  = 1'b0;
    case (r_op)
      OP_SUMA: begin
        w_fin_cout = w_slice_c;
        w_fin_ovf  = w_ovf_add;
      end
      OP_RESTA: begin
        w_fin_cout = w_slice_c;
        w_fin_ovf  = w_ovf_sub;
      end
      OP_SLT: begin
        w_fin_res    = '0;
        w_fin_res[0] = w_slice_r ^ w_ovf_sub;
        w_fin_cout   = w_slice_c;
      end
      OP_SLTU: begin
        w_fin_res    = '0;
        w_fin_res[0] = ~w_slice_c;
        w_fin_cout   = w_slice_c;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_sh_next    = r_sh;
    w_op_next    = r_op;
    w_cnt_next   = r_cnt;
    w_carry_next = r_carry;
    w_res_next   = r_res;
    w_zero_next  = r_zero;
    w_cout_next  = r_cout;
    w_ovf_next   = r_ovf;
    case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state_next = StRun;
          w_a_next     = a_i;
          w_b_next     = b_i;
          w_op_next    = operacion_i;
          w_cnt_next   = '0;
          w_carry_next = (operacion_i == OP_RESTA) || (operacion_i == OP_SLT) ||
                         (operacion_i == OP_SLTU);
        end
      end
      StRun: begin
        w_a_next     = r_a >> 1;
        w_b_next     = r_b >> 1;
        w_sh_next    = w_sh_full[WIDTH-1:1];
        w_carry_next = w_slice_c;
        if (w_last) begin
          w_state_next = StDone;
          w_res_next   = w_fin_res;
          w_zero_next  = (w_fin_res == '0);
          w_cout_next  = w_fin_cout;
          w_ovf_next   = w_fin_ovf;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_op    <= OP_SUMA;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_sh    <= w_sh_next;
      r_op    <= w_op_next;
      r_cnt   <= w_cnt_next;
      r_carry <= w_carry_next;
      r_res   <= w_res_next;
      r_zero  <= w_zero_next;
      r_cout  <= w_cout_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign busy_o      = (r_state != StIdle);
  assign done_o      = (r_state == StDone);
  assign resultado_o = r_res;
  assign zero_o      = r_zero;
  assign carry_o     = r_cout;
  assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: directed and random ops checked against an
// arithmetic reference model, plus start-ignore and mid-run reset scenarios.
module tb_alu_serial;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [W-1:0] a_i, b_i;
  logic [2:0]   op_i;
  logic         busy_o, done_o, zero_o, carry_o, overflow_o;
  logic [W-1:0] resultado_o;

  alu_serial #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .operacion_i (op_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .resultado_o (resultado_o),
    .zero_o      (zero_o),
    .carry_o     (carry_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         ovf;
    int           done_cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic signed_out_of_range(input longint s);
    longint lim;
    lim = longint'(1) << (W - 1);
    return (s > lim - 1) || (s < -lim);
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op);
    exp_t   e;
    longint sa, sb;
    logic [W:0] full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    e.res   = '0;
    e.done_cyc = 0;
    case (op)
      OP_SUMA: begin
        full    = {1'b0, a} + {1'b0, b};
        e.res   = full[W-1:0];
        e.carry = full[W];
        e.ovf   = signed_out_of_range(sa + sb);
      end
      OP_AND:   e.res = a & b;
      OP_OR:    e.res = a | b;
      OP_XOR:   e.res = a ^ b;
      OP_RESTA: begin
        e.res   = a - b;
        e.carry = (a >= b);
        e.ovf   = signed_out_of_range(sa - sb);
      end
      OP_SLT: begin
        e.res   = (sa < sb) ? 1 : 0;
        e.carry = (a >= b);
      end
      OP_SLTU: begin
        e.res   = (a < b) ? 1 : 0;
        e.carry = (a >= b);
      end
      default: e.res = '0;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Monitor: every done_o pulse pops one expectation.
  logic prev_done = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (done_o) begin
      chk("done_single_pulse", 64'(prev_done), 64'd0);
      if (sbq.size() == 0) begin
        chk("done_unexpected", 64'(done_o), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resultado", 64'(resultado_o), 64'(mon_e.res));
        chk("zero",      64'(zero_o),      64'(mon_e.zero));
        chk("carry",     64'(carry_o),     64'(mon_e.carry));
        chk("overflow",  64'(overflow_o),  64'(mon_e.ovf));
        chk("latency",   64'(cyc),         64'(mon_e.done_cyc));
      end
    end
    prev_done = done_o;
  end

  // Waits for IDLE, then drives start for one edge; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                       input bit push);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (busy_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy_o) chk("issue_wait_timeout", 64'(busy_o), 64'd0);
    a_i = a;
    b_i = b;
    op_i = op;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (push) begin
      e = model(a, b, op);
      e.done_cyc = cyc + W;
      sbq.push_back(e);
    end
    a_i = $urandom();
    b_i = $urandom();
    op_i = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || busy_o) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"},      64'(busy_o),      64'd0);
    chk({tag, "_done"},      64'(done_o),      64'd0);
    chk({tag, "_resultado"}, 64'(resultado_o), 64'd0);
    chk({tag, "_zero"},      64'(zero_o),      64'd0);
    chk({tag, "_carry"},     64'(carry_o),     64'd0);
    chk({tag, "_overflow"},  64'(overflow_o),  64'd0);
  endtask

  initial begin
    int t;
    logic [W-1:0] ra, rb;
    rst_ni = 1'b0;
    start_i = 1'b0;
    a_i = '0;
    b_i = '0;
    op_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst_ni = 1'b1;

    // Directed cases from the operation rules.
    issue(32'h7FFF_FFFF, 32'h0000_0001, OP_SUMA, 1);
    issue(32'd5, 32'd5, OP_RESTA, 1);
    issue(32'd0, 32'd1, OP_RESTA, 1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, OP_SLT, 1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, OP_SLTU, 1);
    issue(32'h8000_0000, 32'h7FFF_FFFF, OP_SLT, 1);
    issue(32'hF0F0_F0F0, 32'hFFFF_0000, OP_XOR, 1);
    issue(32'hDEAD_BEEF, 32'h1234_5678, OP_NULA, 1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, OP_SUMA, 1);
    issue(32'h8000_0000, 32'h0000_0001, OP_RESTA, 1);
    drain();

    // start_i during RUN and DONE must be ignored.
    issue(32'd10, 32'd20, OP_SUMA, 1);
    repeat (4) @(negedge clk);
    a_i = 32'hFFFF_FFFF;
    b_i = 32'hFFFF_FFFF;
    op_i = OP_AND;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    t = 0;
    @(negedge clk);
    while (!done_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done", 64'(done_o), 64'd1);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("busy_gap_after_done", 64'(busy_o), 64'd0);
    issue(32'd7, 32'd9, OP_OR, 1);
    @(negedge clk);
    chk("retry_accepted", 64'(busy_o), 64'd1);
    drain();

    // Reset on the edge processing bit 10 aborts; a start in the reset cycle is ignored.
    issue(32'h1234_5678, 32'h0000_1111, OP_SUMA, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check_cleared("midrun_reset");
    issue(32'd2, 32'd3, OP_SUMA, 1);
    drain();

    // Randomized ops with a bias toward boundary operands.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'h8000_0000;
        2: rb = 32'h7FFF_FFFF;
        default: ;
      endcase
      issue(ra, rb, 3'($urandom_range(0, 7)), 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
